// File: rtl/cpu_clk_sched.sv
// Purpose: run-control scheduler issuing cpu_en pulses (halt/step/slow/fast) plus a free-running scan_tick.
// Latency: cpu_en is registered one cycle after a divider tick or step edge; scan_tick is registered on wrap.
// Backpressure: none; cpu_en and scan_tick are fire-and-forget single-cycle enables.
module cpu_clk_sched #(
  parameter logic [31:0] SLOW_DIV = 32'd400_000_000,
  parameter logic [31:0] FAST_DIV = 32'd1,
  parameter logic [31:0] SCAN_DIV = 32'd20_000
) (
  input  logic        clk100MHz,
  input  logic        rst,
  input  logic [1:0]  mode,
  input  logic        step_req,
  input  logic        halt_req,
  input  logic        clr_cnt,
  output logic        cpu_en,
  output logic        scan_tick,
  output logic [2:0]  state,
  output logic [31:0] cycle_cnt
);

  typedef enum logic [2:0] {
    ST_HALT = 3'b000,
    ST_STEP = 3'b001,
    ST_SLOW = 3'b010,
    ST_FAST = 3'b011,
    ST_DONE = 3'b100
  } state_t;

  localparam logic [31:0] SLOW_TERM = SLOW_DIV - 32'd1;
  localparam logic [31:0] FAST_TERM = FAST_DIV - 32'd1;
  localparam logic [31:0] SCAN_TERM = SCAN_DIV - 32'd1;

  state_t      state_q;
  state_t      state_nxt;
  logic [31:0] div_cnt;
  logic [31:0] div_nxt;
  logic [31:0] scan_cnt;
  logic [31:0] cyc_q;
  logic        step_q;
  logic        div_tick;
  logic        step_edge;
  logic        pulse_nxt;

  // Requested run state for a given mode code.
  function automatic state_t mode_to_state(input logic [1:0] m);
    state_t s;
    case (m)
      2'b00:   s = ST_HALT;
      2'b01:   s = ST_STEP;
      2'b10:   s = ST_SLOW;
      default: s = ST_FAST;
    endcase
    return s;
  endfunction

  // Next-state selection: halt_req beats mode in run/step states; DONE waits for mode=00.
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      ST_HALT:                   state_nxt = mode_to_state(mode);
      ST_STEP, ST_SLOW, ST_FAST: state_nxt = halt_req ? ST_DONE : mode_to_state(mode);
      ST_DONE:                   if (mode == 2'b00) state_nxt = ST_HALT;
      default:                   state_nxt = ST_HALT;
    endcase
  end

  // Divider tick, step edge, and the pulse decision (dropped on halt_req or on leaving the state).
  always_comb begin
    div_tick = 1'b0;
    case (state_q)
      ST_SLOW: div_tick = (div_cnt == SLOW_TERM);
      ST_FAST: div_tick = (div_cnt == FAST_TERM);
      default: div_tick = 1'b0;
    endcase
    step_edge = (state_q == ST_STEP) && step_req && !step_q;
    pulse_nxt = (div_tick || step_edge) && !halt_req && (state_nxt == state_q);
  end

  // Divider advance: restarts on any state change, idles at 0 outside SLOW/FAST.
  always_comb begin
    div_nxt = 32'd0;
    if (state_nxt == state_q) begin
      case (state_q)
        ST_SLOW, ST_FAST: div_nxt = div_tick ? 32'd0 : div_cnt + 32'd1;
        default:          div_nxt = 32'd0;
      endcase
    end
  end

  // FSM register with divider and registered cpu_en.
  always_ff @(posedge clk100MHz or negedge rst) begin
    if (!rst) begin
      state_q <= ST_HALT;
      div_cnt <= 32'd0;
      cpu_en  <= 1'b0;
    end else begin
      state_q <= state_nxt;
      div_cnt <= div_nxt;
      cpu_en  <= pulse_nxt;
    end
  end

  // Step button history, tracked in every state so entering STEP with the button held gives no pulse.
  always_ff @(posedge clk100MHz or negedge rst) begin
    if (!rst) begin
      step_q <= 1'b0;
    end else begin
      step_q <= step_req;
    end
  end

  // Free-running display scan divider, independent of run control.
  always_ff @(posedge clk100MHz or negedge rst) begin
    if (!rst) begin
      scan_cnt  <= 32'd0;
      scan_tick <= 1'b0;
    end else begin
      scan_tick <= (scan_cnt == SCAN_TERM);
      scan_cnt  <= (scan_cnt == SCAN_TERM) ? 32'd0 : scan_cnt + 32'd1;
    end
  end

  // Saturating count of issued cpu_en pulses; clear wins over a coincident pulse.
  always_ff @(posedge clk100MHz or negedge rst) begin
    if (!rst) begin
      cyc_q <= 32'd0;
    end else if (clr_cnt) begin
      cyc_q <= 32'd0;
    end else if (cpu_en && (cyc_q != 32'hFFFF_FFFF)) begin
      cyc_q <= cyc_q + 32'd1;
    end
  end

  assign state     = state_q;
  assign cycle_cnt = cyc_q;

endmodule

// File: tb/tb_cpu_clk_sched.sv
// Directed bench for cpu_clk_sched with SLOW_DIV=8, FAST_DIV=1, SCAN_DIV=4.
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_cpu_clk_sched;

  logic        clk100MHz;
  logic        rst;
  logic [1:0]  mode;
  logic        step_req;
  logic        halt_req;
  logic        clr_cnt;
  logic        cpu_en;
  logic        scan_tick;
  logic [2:0]  state;
  logic [31:0] cycle_cnt;

  int checks;
  int failures;

  cpu_clk_sched #(
    .SLOW_DIV(32'd8),
    .FAST_DIV(32'd1),
    .SCAN_DIV(32'd4)
  ) dut (
    .clk100MHz(clk100MHz),
    .rst(rst),
    .mode(mode),
    .step_req(step_req),
    .halt_req(halt_req),
    .clr_cnt(clr_cnt),
    .cpu_en(cpu_en),
    .scan_tick(scan_tick),
    .state(state),
    .cycle_cnt(cycle_cnt)
  );

  initial clk100MHz = 1'b0;
  always #5 clk100MHz = ~clk100MHz;

  task automatic tick();
    @(posedge clk100MHz);
    #1;
  endtask

  task automatic test_reset();
    logic exp_b;
    rst = 1'b0; mode = 2'b00; step_req = 1'b0; halt_req = 1'b0; clr_cnt = 1'b0;
    repeat (3) tick();
    checks++; if (cpu_en !== 1'b0) begin failures++; $display("FAIL reset_cpu_en got=%0b exp=0", cpu_en); end
    checks++; if (scan_tick !== 1'b0) begin failures++; $display("FAIL reset_scan_tick got=%0b exp=0", scan_tick); end
    checks++; if (state !== 3'b000) begin failures++; $display("FAIL reset_state got=%b exp=000", state); end
    checks++; if (cycle_cnt !== 32'd0) begin failures++; $display("FAIL reset_cycle_cnt got=%0d exp=0", cycle_cnt); end
    rst = 1'b1;
    for (int k = 1; k <= 50; k++) begin
      tick();
      exp_b = ((k % 4) == 0);
      checks++; if (cpu_en !== 1'b0) begin failures++; $display("FAIL idle_cpu_en cyc=%0d got=%0b exp=0", k, cpu_en); end
      checks++; if (scan_tick !== exp_b) begin failures++; $display("FAIL idle_scan_tick cyc=%0d got=%0b exp=%0b", k, scan_tick, exp_b); end
    end
    checks++; if (state !== 3'b000) begin failures++; $display("FAIL idle_state got=%b exp=000", state); end
  endtask

  task automatic test_slow_fast();
    logic exp_b;
    mode = 2'b10;
    tick();
    checks++; if (state !== 3'b010) begin failures++; $display("FAIL slow_state got=%b exp=010", state); end
    for (int k = 1; k <= 41; k++) begin
      tick();
      exp_b = ((k % 8) == 0);
      checks++; if (cpu_en !== exp_b) begin failures++; $display("FAIL slow_cpu_en cyc=%0d got=%0b exp=%0b", k, cpu_en, exp_b); end
    end
    checks++; if (cycle_cnt !== 32'd5) begin failures++; $display("FAIL slow_cycle_cnt got=%0d exp=5", cycle_cnt); end
    mode = 2'b11;
    tick();
    checks++; if (state !== 3'b011) begin failures++; $display("FAIL fast_state got=%b exp=011", state); end
    checks++; if (dut.div_cnt !== 32'd0) begin failures++; $display("FAIL fast_div_clear got=%0d exp=0", dut.div_cnt); end
    checks++; if (cpu_en !== 1'b0) begin failures++; $display("FAIL fast_switch_cpu_en got=%0b exp=0", cpu_en); end
    for (int k = 1; k <= 10; k++) begin
      tick();
      checks++; if (cpu_en !== 1'b1) begin failures++; $display("FAIL fast_cpu_en cyc=%0d got=%0b exp=1", k, cpu_en); end
    end
    checks++; if (cycle_cnt !== 32'd14) begin failures++; $display("FAIL fast_cycle_cnt got=%0d exp=14", cycle_cnt); end
  endtask

  task automatic test_step();
    mode = 2'b01;
    tick();
    checks++; if (state !== 3'b001) begin failures++; $display("FAIL step_state got=%b exp=001", state); end
    checks++; if (cpu_en !== 1'b0) begin failures++; $display("FAIL step_entry_cpu_en got=%0b exp=0", cpu_en); end
    checks++; if (cycle_cnt !== 32'd15) begin failures++; $display("FAIL step_base_cnt got=%0d exp=15", cycle_cnt); end
    tick();
    checks++; if (cpu_en !== 1'b0) begin failures++; $display("FAIL step_idle_cpu_en got=%0b exp=0", cpu_en); end
    step_req = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k == 1) begin
        checks++; if (cpu_en !== 1'b1) begin failures++; $display("FAIL step_press1 got=%0b exp=1", cpu_en); end
      end else begin
        checks++; if (cpu_en !== 1'b0) begin failures++; $display("FAIL step_hold cyc=%0d got=%0b exp=0", k, cpu_en); end
      end
    end
    step_req = 1'b0;
    repeat (3) tick();
    step_req = 1'b1;
    tick();
    checks++; if (cpu_en !== 1'b1) begin failures++; $display("FAIL step_press2 got=%0b exp=1", cpu_en); end
    step_req = 1'b0;
    repeat (3) tick();
    checks++; if (cycle_cnt !== 32'd17) begin failures++; $display("FAIL step_cycle_cnt got=%0d exp=17", cycle_cnt); end
  endtask

  task automatic test_halt();
    mode = 2'b11;
    tick();
    tick();
    checks++; if (cpu_en !== 1'b1) begin failures++; $display("FAIL halt_pre_cpu_en got=%0b exp=1", cpu_en); end
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    checks++; if (cpu_en !== 1'b0) begin failures++; $display("FAIL halt_cpu_en got=%0b exp=0", cpu_en); end
    checks++; if (state !== 3'b100) begin failures++; $display("FAIL halt_state got=%b exp=100", state); end
    for (int k = 1; k <= 5; k++) begin
      tick();
      checks++; if (cpu_en !== 1'b0) begin failures++; $display("FAIL done_cpu_en cyc=%0d got=%0b exp=0", k, cpu_en); end
    end
    mode = 2'b10;
    repeat (3) tick();
    checks++; if (state !== 3'b100) begin failures++; $display("FAIL done_hold_state got=%b exp=100", state); end
    mode = 2'b00;
    tick();
    checks++; if (state !== 3'b000) begin failures++; $display("FAIL done_exit_state got=%b exp=000", state); end
    mode = 2'b10;
    tick();
    checks++; if (state !== 3'b010) begin failures++; $display("FAIL resume_state got=%b exp=010", state); end
    for (int k = 1; k <= 8; k++) begin
      tick();
      checks++; if (cpu_en !== (k == 8)) begin failures++; $display("FAIL resume_cpu_en cyc=%0d got=%0b exp=%0b", k, cpu_en, (k == 8)); end
    end
  endtask

  task automatic test_counter();
    mode = 2'b11;
    tick();
    force dut.cyc_q = 32'hFFFF_FFFD;
    #1;
    release dut.cyc_q;
    repeat (5) tick();
    checks++; if (cycle_cnt !== 32'hFFFF_FFFF) begin failures++; $display("FAIL sat_cycle_cnt got=%h exp=ffffffff", cycle_cnt); end
    checks++; if (cpu_en !== 1'b1) begin failures++; $display("FAIL sat_cpu_en got=%0b exp=1", cpu_en); end
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    checks++; if (cycle_cnt !== 32'd0) begin failures++; $display("FAIL clr_cycle_cnt got=%0d exp=0", cycle_cnt); end
    tick();
    checks++; if (cycle_cnt !== 32'd1) begin failures++; $display("FAIL post_clr_cnt got=%0d exp=1", cycle_cnt); end
  endtask

  task automatic test_async_reset();
    logic exp_b;
    mode = 2'b10;
    tick();
    repeat (8) tick();
    checks++; if (cpu_en !== 1'b1) begin failures++; $display("FAIL areset_pre_cpu_en got=%0b exp=1", cpu_en); end
    checks++; if (cycle_cnt !== 32'd2) begin failures++; $display("FAIL areset_pre_cnt got=%0d exp=2", cycle_cnt); end
    #3;
    rst = 1'b0;
    #1;
    checks++; if (cpu_en !== 1'b0) begin failures++; $display("FAIL areset_cpu_en got=%0b exp=0", cpu_en); end
    checks++; if (state !== 3'b000) begin failures++; $display("FAIL areset_state got=%b exp=000", state); end
    checks++; if (cycle_cnt !== 32'd0) begin failures++; $display("FAIL areset_cycle_cnt got=%0d exp=0", cycle_cnt); end
    mode = 2'b00;
    repeat (2) tick();
    rst = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      exp_b = ((k % 4) == 0);
      checks++; if (scan_tick !== exp_b) begin failures++; $display("FAIL areset_scan cyc=%0d got=%0b exp=%0b", k, scan_tick, exp_b); end
      checks++; if (cpu_en !== 1'b0) begin failures++; $display("FAIL areset_post_cpu_en cyc=%0d got=%0b exp=0", k, cpu_en); end
    end
    checks++; if (state !== 3'b000) begin failures++; $display("FAIL areset_post_state got=%b exp=000", state); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b0; mode = 2'b00; step_req = 1'b0; halt_req = 1'b0; clr_cnt = 1'b0;
    test_reset();
    test_slow_fast();
    test_step();
    test_halt();
    test_counter();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
